// File: rtl/present_round_iter.sv
// Iterative PRESENT-style round engine: NUM_SBOX parallel 4-bit S-boxes plus key XOR, ROUNDS rounds per start.
// Define PRESENT_ROUND_DUP_EN to add a shadow datapath that flags faults and suppresses the faulty result.
module present_round_iter #(
  parameter int NUM_SBOX = 4,
  parameter int ROUNDS   = 4,
  localparam int W  = 4 * NUM_SBOX,
  localparam int CW = $clog2(ROUNDS + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_start,
  input  logic [W-1:0] io_state,
  input  logic [W-1:0] io_key,
  output logic [W-1:0] io_out,
  output logic         io_busy,
  output logic         io_done,
  output logic         io_fault
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fsm_t;

  fsm_t          fsm_q;
  logic [W-1:0]  state_q;
  logic [W-1:0]  key_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  round_d;
  logic          last_round;
  logic          accept;
  logic          mismatch;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [W-1:0] sbox_layer(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SBOX; i++) begin
      r[4*i +: 4] = sbox4(s[4*i +: 4]);
    end
    return r;
  endfunction

  assign round_d    = sbox_layer(state_q) ^ key_q;
  assign last_round = (cnt_q == CW'(ROUNDS - 1));
  // A latched fault blocks any new operation until reset.
  assign accept     = ((fsm_q == IDLE) || (fsm_q == DONE)) && io_start && !io_fault;
  assign io_busy    = (fsm_q == LOAD) || (fsm_q == RUN);
  assign io_done    = (fsm_q == DONE);

`ifdef PRESENT_ROUND_DUP_EN
  logic [W-1:0]  state_dup_q;
  logic [CW-1:0] cnt_dup_q;
  logic [W-1:0]  round_dup;
  logic          fault_q;

  assign round_dup = sbox_layer(state_dup_q) ^ key_q;
  // Comparing next values too catches a divergence on the final round before DONE is entered.
  assign mismatch  = (fsm_q == RUN) &&
                     ((state_q != state_dup_q) || (cnt_q != cnt_dup_q) || (round_d != round_dup));
  assign io_fault  = fault_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_dup_q <= '0;
      cnt_dup_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (mismatch) begin
        fault_q <= 1'b1;
      end
      if (accept) begin
        state_dup_q <= io_state;
        cnt_dup_q   <= '0;
      end else if ((fsm_q == RUN) && !mismatch) begin
        state_dup_q <= round_dup;
        cnt_dup_q   <= cnt_dup_q + 1'b1;
      end
    end
  end
`else
  assign mismatch = 1'b0;
  assign io_fault = 1'b0;
`endif

  // Main FSM: capture on accept, one idle LOAD cycle, then one round per RUN cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      io_out  <= '0;
    end else begin
      case (fsm_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= io_state;
            key_q   <= io_key;
            cnt_q   <= '0;
            fsm_q   <= LOAD;
          end else begin
            fsm_q <= IDLE;
          end
        end
        LOAD: fsm_q <= RUN;
        RUN: begin
          if (mismatch) begin
            fsm_q  <= IDLE;
            io_out <= '0;
          end else begin
            state_q <= round_d;
            cnt_q   <= cnt_q + 1'b1;
            if (last_round) begin
              fsm_q  <= DONE;
              io_out <= round_d;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/present_round_iter.md
# present_round_iter

Iterative, parametrised PRESENT-style round engine for the fault-vulnerability case studies. Each round applies NUM_SBOX parallel 4-bit PRESENT S-boxes to a registered state and then XORs a key. The engine runs ROUNDS rounds under a start/done handshake. An optional duplicated datapath with per-cycle comparison detects injected faults and suppresses the faulty output.

## Interface
- NUM_SBOX, 4, number of parallel S-boxes; state width W = 4*NUM_SBOX
- ROUNDS, 4, rounds per operation, ≥1; round counter width = clog2(ROUNDS+1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_start  in  1  operation request; sampled only when FSM is IDLE or DONE
- io_state  in  W  plaintext state, captured on accepted io_start
- io_key  in  W  round key, captured on accepted io_start; same key every round
- io_out  out  W  result register
- io_busy  out  1  high while FSM is in LOAD or RUN
- io_done  out  1  one-cycle pulse when io_out is updated
- io_fault  out  1  sticky fault flag; constant 0 without DUP_EN

## Operation
- Nibble i is bits [4i+3:4i], and bit 0 of a nibble is its LSB.
- S-box table, input 0..F: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- Round function: state <= S(state) ^ key, with the S-box applied nibble-wise.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: waits for io_start.
  - io_start=1 captures io_state into state_q and io_key into key_q, clears cnt_q, and moves to LOAD.
- LOAD: one cycle, no computation; moves to RUN.
- RUN: applies one round per cycle and increments cnt_q.
  - When cnt_q reaches ROUNDS-1, that same edge applies the last round and moves to DONE.
- DONE: io_out <= state_q is written on entry and io_done=1 for this cycle.
  - io_start=1 here captures new operands and moves to LOAD (back-to-back).
  - Otherwise the FSM moves to IDLE.
- io_start while in LOAD or RUN is ignored; there is no queueing.
- io_out holds its value until the next DONE entry.
- io_state and io_key may change freely after capture.
- Reset (async, any state, including mid-RUN):
  - FSM = IDLE; cnt_q, state_q, key_q, io_out = 0.
  - io_busy = io_done = io_fault = 0.
  - No partial result is ever presented.

## Timing
- io_start is accepted at edge t0.
- io_busy is high for cycles t0+1 .. t0+ROUNDS+1.
- io_done is high in cycle t0+ROUNDS+2, together with the valid io_out.
- Latency is ROUNDS+2 cycles from start acceptance to io_done.
- Back-to-back throughput is one result every ROUNDS+2 cycles.
- All outputs are registered or decoded directly from FSM state; there is no combinational input-to-output path.

## Configuration
- Macro: PRESENT_ROUND_DUP_EN.
- Defined:
  - Adds a shadow state register state_dup_q and a shadow S-box/key-add layer driven from key_q.
  - Adds a shadow round counter cnt_dup_q.
  - Shadow registers load and update identically to the main path.
- Mismatch detection:
  - Every cycle in RUN and on DONE entry, state_q != state_dup_q or cnt_q != cnt_dup_q sets io_fault.
  - On mismatch the FSM moves to IDLE on the next edge, io_done is not pulsed, and io_out is forced to 0.
  - io_fault stays set until reset.
  - While io_fault=1, io_start is ignored.
- Undefined:
  - No shadow logic is present.
  - io_fault is tied to 0.
  - The FSM behaves as described above with no abort path.

## Test plan
- NUM_SBOX=4, ROUNDS=1, io_state=0x0000, io_key=0x0000 -> io_out=0xCCCC; io_done in cycle t0+3.
- ROUNDS=1, io_state=0x0000, io_key=0xFFFF -> 0x3333.
- ROUNDS=4 (default), io_state=0x0000, io_key=0x0000 -> chain C,4,9,E gives io_out=0xEEEE; io_done in t0+6; io_busy high for exactly 5 cycles.
- Back-to-back operation:
  - io_start held high through DONE -> second operation begins with no IDLE cycle.
  - io_start pulsed mid-RUN -> ignored; the result is unchanged.
- Reset asserted mid-RUN (cnt_q=2) -> io_busy, io_done, io_out all 0 immediately.
  - After release, a fresh start gives the correct 0xEEEE.
- With PRESENT_ROUND_DUP_EN, force one bit of state_dup_q in cycle t0+3:
  - io_fault=1 from the next cycle, no io_done, io_out=0.
  - A later io_start is ignored until reset.
  - Without the macro, io_fault stays 0 in every scenario.
